// File: rtl/pipe_stage_buf.sv
// Elastic pipeline stage: DEPTH-entry in-order buffer with ready/valid on both sides and flush.
// Optional stall/full cycle counters are enabled by defining PIPE_STALL_CNT_EN.
module pipe_stage_buf #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              flush_in,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  count
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [31:0]       stall_cnt,
    output logic [31:0]       full_cycles
`endif
);

    localparam int unsigned       PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_cnt;

    logic [PTR_W-1:0]  w_wr_ptr_nxt;
    logic [PTR_W-1:0]  w_rd_ptr_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;

    // in_ready depends on registered occupancy only, so no out_ready -> in_ready path exists.
    assign w_full    = (r_cnt == FULL_CNT);
    assign w_empty   = (r_cnt == '0);
    assign in_ready  = !w_full;
    assign out_valid = !w_empty;
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
    assign count     = r_cnt;

    assign w_push = in_valid && in_ready && !flush_in;
    assign w_pop  = out_valid && out_ready;

    always_comb begin
        w_wr_ptr_nxt = r_wr_ptr;
        w_rd_ptr_nxt = r_rd_ptr;
        w_cnt_nxt    = r_cnt;
        if (flush_in) begin
            w_wr_ptr_nxt = '0;
            w_rd_ptr_nxt = '0;
            w_cnt_nxt    = '0;
        end else begin
            if (w_push) begin
                w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   w_cnt_nxt = r_cnt + CNT_W'(1);
                2'b01:   w_cnt_nxt = r_cnt - CNT_W'(1);
                default: w_cnt_nxt = r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            r_wr_ptr <= w_wr_ptr_nxt;
            r_rd_ptr <= w_rd_ptr_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    // Payload storage is not reset; out_data is gated by out_valid instead.
    always_ff @(posedge clk_in) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

`ifdef PIPE_STALL_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_full_cycles;

    // Saturating counters; flush intentionally leaves them alone.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_stall_cnt   <= '0;
            r_full_cycles <= '0;
        end else begin
            if (out_valid && !out_ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (w_full && (r_full_cycles != '1)) begin
                r_full_cycles <= r_full_cycles + 32'd1;
            end
        end
    end

    assign stall_cnt   = r_stall_cnt;
    assign full_cycles = r_full_cycles;
`endif

`ifndef SYNTHESIS
    a_cnt_bound : assert property (@(posedge clk_in) disable iff (!rst_in) r_cnt <= FULL_CNT);
    a_no_push_full : assert property (@(posedge clk_in) disable iff (!rst_in) w_full |-> !w_push);
`endif

endmodule
